// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// The state names match the receiver's FSM so the two read alike in waveforms.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_states_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clock of every bit while enabled.
// Kept free of transmitter specifics so a receiver can reuse it.
module uart_baud_gen #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  if (BIT_CYCLES < 2) begin : g_rate_check
    $error("uart_baud_gen: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  logic [CNT_W-1:0] cnt;

  // Held at zero while disabled, so the first bit after enable is full length.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, LSB-first framing with optional
// parity and one or two stop bits, registered serial output.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BCNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_WIDTH - 1);
  localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_check
    $error("uart_tx: DATA_WIDTH must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_parity_check
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_states_e            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCNT_W-1:0]     bit_cnt;
  logic                  parity_bit;
  logic                  bit_tick;

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state != IDLE),
    .bit_tick(bit_tick)
  );

  // NOTE: tx_o is loaded with the level of the state being entered, in the
  // same non-blocking update as the state, so the pin is a flop output and
  // changes on exactly the edge the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_o       <= 1'b1;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            state      <= START;
            shreg      <= data_i;
            parity_bit <= (PARITY == PARITY_ODD) ? ~^data_i : ^data_i;
            tx_o       <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_o    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= uart_tx_pkg::PARITY;
                tx_o  <= parity_bit;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
              shreg   <= shreg >> 1;
              tx_o    <= shreg[1];
            end
          end
        end
        uart_tx_pkg::PARITY: begin
          if (bit_tick) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx_o    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_STOP) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
            tx_o <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  // Decoded from flops only; high during the final clock of the last stop bit.
  assign done_o  = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (8N1, 8E1, 8O1, 8E2) at
// BIT_CYCLES=10, driven from a table of frames plus hand-written corner cases.
module tb_uart_tx;

  localparam int BIT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] valid = '0;
  logic [7:0] data [4];
  logic [3:0] tx, ready, busy, done;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .data_i(data[2]), .valid_i(valid[2]),
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY(2), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst(rst), .data_i(data[3]), .valid_i(valid[3]),
    .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_idle(input int cfg, input string tag);
    check($sformatf("%s cfg%0d tx", tag, cfg), tx[cfg], 1);
    check($sformatf("%s cfg%0d ready", tag, cfg), ready[cfg], 1);
    check($sformatf("%s cfg%0d busy", tag, cfg), busy[cfg], 0);
    check($sformatf("%s cfg%0d done", tag, cfg), done[cfg], 0);
  endtask

  // Called at a negedge; presents the word for one handshake cycle, then
  // scrambles data_i so a late sample would show up on the line.
  task automatic start_frame(input int cfg, input logic [7:0] d);
    valid[cfg] = 1'b1;
    data[cfg]  = d;
    @(negedge clk);
    valid[cfg] = 1'b0;
    data[cfg]  = ~d;
  endtask

  // Checks frame cycles 1..nbits*BIT; line[k] is the level of bit k.
  // inject_at pulses a stray valid, abort_at applies a one-cycle reset.
  task automatic run_frame(input int cfg, input logic [15:0] line, input int nbits,
                           input int inject_at, input int abort_at);
    int len = nbits * BIT;
    for (int c = 1; c <= len; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      check($sformatf("cfg%0d cyc%0d tx", cfg, c), tx[cfg], line[(c-1)/BIT]);
      check($sformatf("cfg%0d cyc%0d ready", cfg, c), ready[cfg], 0);
      check($sformatf("cfg%0d cyc%0d busy", cfg, c), busy[cfg], 1);
      check($sformatf("cfg%0d cyc%0d done", cfg, c), done[cfg], (c == len) ? 1 : 0);
      if (inject_at > 0 && c == inject_at) begin
        valid[cfg] = 1'b1;
        data[cfg]  = 8'h3C;
      end else if (inject_at > 0 && c == inject_at + 1) begin
        valid[cfg] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    string       name;
    int          cfg;
    logic [7:0]  data;
    logic [15:0] line;   // {stop(s), parity, data, start}, bit 0 first on the wire
    int          nbits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"8N1 A5", 0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10};
    vecs[1] = '{"8E1 A5", 1, 8'hA5, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
    vecs[2] = '{"8O1 A5", 2, 8'hA5, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
    vecs[3] = '{"8E2 01", 3, 8'h01, {4'b0, 2'b11, 1'b1, 8'h01, 1'b0}, 12};
    vecs[4] = '{"8E1 07", 1, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11};
    vecs[5] = '{"8O1 07", 2, 8'h07, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11};

    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    // Reset held for three edges, then idle-line stability
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) check_idle(i, "reset");
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check_idle(i, "idle");
    end

    // Table of single frames
    foreach (vecs[v]) begin
      check_idle(vecs[v].cfg, vecs[v].name);
      start_frame(vecs[v].cfg, vecs[v].data);
      run_frame(vecs[v].cfg, vecs[v].line, vecs[v].nbits, 0, 0);
      check_idle(vecs[v].cfg, {vecs[v].name, " end"});
      repeat (3) @(negedge clk);
    end

    // Back-to-back with valid held high; data_i changes mid-frame
    valid[0] = 1'b1;
    data[0]  = 8'h00;
    @(negedge clk);
    data[0] = 8'hFF;
    run_frame(0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 0, 0);
    check_idle(0, "b2b gap");
    @(negedge clk);
    valid[0] = 1'b0;
    run_frame(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 0, 0);
    check_idle(0, "b2b end");
    repeat (3) @(negedge clk);

    // Stray valid mid-frame is ignored
    start_frame(0, 8'hA5);
    run_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 35, 0);
    check_idle(0, "ignored end");
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check($sformatf("ignored quiet cyc%0d busy", c), busy[0], 0);
      check($sformatf("ignored quiet cyc%0d tx", c), tx[0], 1);
    end

    // Reset during data bit 3 (cycles 41..50), then a fresh frame
    start_frame(0, 8'hA5);
    run_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 0, 45);
    check_idle(0, "abort");
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      check($sformatf("abort quiet cyc%0d done", c), done[0], 0);
      check($sformatf("abort quiet cyc%0d tx", c), tx[0], 1);
    end
    start_frame(0, 8'h5A);
    run_frame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 0, 0);
    check_idle(0, "after abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
